// File: rtl/jtcontra_rom_slot.sv
// ---------------------------------------------------------------------------
// jtcontra_rom_slot
//
// Responder end of a graphics ROM request interface. Each requester access
// (rom_cs/rom_addr) becomes one request/acknowledge/data-ready transaction on
// the SDRAM controller port. The last word fetched is kept in a one-word cache,
// so a repeated address is answered in one cycle without touching SDRAM.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   downloading  ROM download in progress: flushes cache, blocks new requests
//   rom_cs       requester wants the word at rom_addr
//   rom_addr     requester word address (AW bits)
//   rom_ok       rom_data is valid for the current rom_addr
//   rom_data     read data (registered)
//   sdram_req    request level to the controller, held until sdram_ack
//   sdram_addr   request word address (OFFSET + rom_addr, wraps)
//   sdram_ack    controller accepted the request (one-cycle pulse)
//   data_rdy     sdram_din valid (one-cycle pulse)
//   sdram_din    SDRAM read data
// ---------------------------------------------------------------------------
module jtcontra_rom_slot #(
  parameter int                    AW       = 18,
  parameter int                    SDRAM_AW = 22,
  parameter logic [SDRAM_AW-1:0]   OFFSET   = 22'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  downloading,
  input  logic                  rom_cs,
  input  logic [AW-1:0]         rom_addr,
  output logic                  rom_ok,
  output logic [15:0]           rom_data,
  output logic                  sdram_req,
  output logic [SDRAM_AW-1:0]   sdram_addr,
  input  logic                  sdram_ack,
  input  logic                  data_rdy,
  input  logic [15:0]           sdram_din
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t                state_r;
  logic                  ok_reg_r;
  logic [AW-1:0]         ok_addr_r;
  logic                  cache_valid_r;
  logic [AW-1:0]         cache_addr_r;
  logic [15:0]           cache_data_r;
  logic [AW-1:0]         lat_addr_r;
  // Set when a download overlapped the transaction in flight; its data must
  // not reach the cache even if downloading has already dropped again.
  logic                  drop_r;

  logic                  hit_s;
  logic                  discard_s;
  logic                  lat_match_s;
  logic [SDRAM_AW-1:0]   req_addr_s;

  // Combinational decode of hit, discard and request address
  always_comb begin
    hit_s       = cache_valid_r & (rom_addr == cache_addr_r);
    discard_s   = drop_r | downloading;
    lat_match_s = rom_cs & (rom_addr == lat_addr_r);
    // zero-extend then add; the sum wraps naturally at SDRAM_AW bits
    req_addr_s  = SDRAM_AW'(rom_addr) + OFFSET;
  end

  // Gate the registered ok so a stale value never survives an address change
  assign rom_ok = ok_reg_r & rom_cs & (rom_addr == ok_addr_r) & ~downloading;

  // Transaction state machine, cache and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      ok_reg_r      <= 1'b0;
      ok_addr_r     <= '0;
      cache_valid_r <= 1'b0;
      cache_addr_r  <= '0;
      cache_data_r  <= 16'h0000;
      lat_addr_r    <= '0;
      drop_r        <= 1'b0;
      rom_data      <= 16'h0000;
      sdram_req     <= 1'b0;
      sdram_addr    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (rom_cs && !downloading) begin
            if (hit_s) begin
              rom_data  <= cache_data_r;
              ok_reg_r  <= 1'b1;
              ok_addr_r <= rom_addr;
            end else begin
              ok_reg_r   <= 1'b0;
              sdram_req  <= 1'b1;
              sdram_addr <= req_addr_s;
              lat_addr_r <= rom_addr;
              drop_r     <= 1'b0;
              state_r    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            // data may arrive together with the ack
            if (data_rdy) begin
              if (!discard_s) begin
                cache_data_r  <= sdram_din;
                cache_addr_r  <= lat_addr_r;
                cache_valid_r <= 1'b1;
                if (lat_match_s) begin
                  rom_data  <= sdram_din;
                  ok_reg_r  <= 1'b1;
                  ok_addr_r <= lat_addr_r;
                end
              end
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (data_rdy) begin
            if (!discard_s) begin
              cache_data_r  <= sdram_din;
              cache_addr_r  <= lat_addr_r;
              cache_valid_r <= 1'b1;
              if (lat_match_s) begin
                rom_data  <= sdram_din;
                ok_reg_r  <= 1'b1;
                ok_addr_r <= lat_addr_r;
              end
            end
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          sdram_req <= 1'b0;
          ok_reg_r  <= 1'b0;
        end
      endcase

      // A download flushes everything; these assignments take priority
      if (downloading) begin
        cache_valid_r <= 1'b0;
        ok_reg_r      <= 1'b0;
        if (state_r != ST_IDLE) begin
          drop_r <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jtcontra_rom_slot.sv
// ---------------------------------------------------------------------------
// tb_jtcontra_rom_slot
//
// Directed bench for jtcontra_rom_slot. The main instance uses OFFSET
// 22'h100000; a second instance with OFFSET 22'h3FFFFF covers address
// wrap-around and reset in the middle of a request.
// ---------------------------------------------------------------------------
module tb_jtcontra_rom_slot;

  logic        clk;
  logic        rst_n;
  logic        downloading;
  logic        rom_cs;
  logic [17:0] rom_addr;
  logic        rom_ok;
  logic [15:0] rom_data;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack;
  logic        data_rdy;
  logic [15:0] sdram_din;

  logic        rom_cs2;
  logic [17:0] rom_addr2;
  logic        rom_ok2;
  logic [15:0] rom_data2;
  logic        sdram_req2;
  logic [21:0] sdram_addr2;
  logic        sdram_ack2;
  logic        data_rdy2;
  logic [15:0] sdram_din2;

  int checks;
  int errors;
  int req_cycles;

  jtcontra_rom_slot #(.AW(18), .SDRAM_AW(22), .OFFSET(22'h100000)) dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_ok(rom_ok), .rom_data(rom_data),
    .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
    .data_rdy(data_rdy), .sdram_din(sdram_din)
  );

  jtcontra_rom_slot #(.AW(18), .SDRAM_AW(22), .OFFSET(22'h3FFFFF)) dut2 (
    .clk(clk), .rst_n(rst_n), .downloading(1'b0),
    .rom_cs(rom_cs2), .rom_addr(rom_addr2), .rom_ok(rom_ok2), .rom_data(rom_data2),
    .sdram_req(sdram_req2), .sdram_addr(sdram_addr2), .sdram_ack(sdram_ack2),
    .data_rdy(data_rdy2), .sdram_din(sdram_din2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ack for one cycle, then data_rdy with din on the following cycle
  task automatic serve(input logic [15:0] din);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    data_rdy  = 1'b1;
    sdram_din = din;
    tick();
    data_rdy  = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    downloading = 1'b0;
    rom_cs      = 1'b0;
    rom_addr    = 18'h0;
    sdram_ack   = 1'b0;
    data_rdy    = 1'b0;
    sdram_din   = 16'h0;
    rom_cs2     = 1'b0;
    rom_addr2   = 18'h0;
    sdram_ack2  = 1'b0;
    data_rdy2   = 1'b0;
    sdram_din2  = 16'h0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ok",   32'(rom_ok),     32'h0);
    chk("rst_req",  32'(sdram_req),  32'h0);
    chk("rst_addr", 32'(sdram_addr), 32'h0);
    chk("rst_data", 32'(rom_data),   32'h0);

    // first miss: ack 2 cycles after req is seen, data 5 cycles after ack
    rst_n    = 1'b1;
    rom_cs   = 1'b1;
    rom_addr = 18'h00123;
    req_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (sdram_req) req_cycles++;
      if (i == 0) chk("t1_addr", 32'(sdram_addr), 32'h100123);
    end
    sdram_ack = 1'b1;
    tick();
    if (sdram_req) req_cycles++;
    sdram_ack = 1'b0;
    chk("t1_req_cycles", 32'(req_cycles), 32'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_wait_ok", 32'(rom_ok), 32'h0);
    end
    data_rdy  = 1'b1;
    sdram_din = 16'hBEEF;
    tick();
    data_rdy  = 1'b0;
    chk("t1_ok",   32'(rom_ok),   32'h1);
    chk("t1_data", 32'(rom_data), 32'hBEEF);

    // repeat address after rom_cs low for a cycle: cache hit
    rom_cs = 1'b0;
    tick();
    chk("t2_cs_low_ok", 32'(rom_ok), 32'h0);
    rom_cs = 1'b1;
    tick();
    chk("t2_hit_ok",   32'(rom_ok),    32'h1);
    chk("t2_hit_data", 32'(rom_data),  32'hBEEF);
    chk("t2_no_req",   32'(sdram_req), 32'h0);

    // address change right after a hit
    rom_addr = 18'h00124;
    #1;
    chk("t3_stale_ok", 32'(rom_ok), 32'h0);
    tick();
    chk("t3_req",  32'(sdram_req),  32'h1);
    chk("t3_addr", 32'(sdram_addr), 32'h100124);
    serve(16'h1234);
    chk("t3_ok",   32'(rom_ok),   32'h1);
    chk("t3_data", 32'(rom_data), 32'h1234);

    // address change while waiting for data
    rom_addr = 18'h00200;
    tick();
    chk("t4_addr1", 32'(sdram_addr), 32'h100200);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    rom_addr  = 18'h00300;
    data_rdy  = 1'b1;
    sdram_din = 16'h2222;
    tick();
    data_rdy  = 1'b0;
    chk("t4_first_ok",   32'(rom_ok),   32'h0);
    chk("t4_first_data", 32'(rom_data), 32'h1234);
    tick();
    chk("t4_req2",  32'(sdram_req),  32'h1);
    chk("t4_addr2", 32'(sdram_addr), 32'h100300);
    serve(16'h3333);
    chk("t4_ok",   32'(rom_ok),   32'h1);
    chk("t4_data", 32'(rom_data), 32'h3333);

    // download pulse while waiting: data discarded, cache flushed
    rom_addr = 18'h00400;
    tick();
    chk("t5_addr1", 32'(sdram_addr), 32'h100400);
    sdram_ack = 1'b1;
    tick();
    sdram_ack   = 1'b0;
    downloading = 1'b1;
    tick();
    downloading = 1'b0;
    data_rdy    = 1'b1;
    sdram_din   = 16'h4444;
    tick();
    data_rdy    = 1'b0;
    chk("t5_discard_ok", 32'(rom_ok), 32'h0);
    tick();
    chk("t5_req2",  32'(sdram_req),  32'h1);
    chk("t5_addr2", 32'(sdram_addr), 32'h100400);
    serve(16'h5555);
    chk("t5_ok",   32'(rom_ok),   32'h1);
    chk("t5_data", 32'(rom_data), 32'h5555);

    // offset wrap-around on the second instance
    rom_cs2   = 1'b1;
    rom_addr2 = 18'h00002;
    tick();
    chk("t6_req",  32'(sdram_req2),  32'h1);
    chk("t6_addr", 32'(sdram_addr2), 32'h000001);

    // reset while in REQ, then a late ack
    rst_n = 1'b0;
    #1;
    chk("t7_req_rst",  32'(sdram_req2), 32'h0);
    chk("t7_ok2_rst",  32'(rom_ok2),    32'h0);
    chk("t7_ok_rst",   32'(rom_ok),     32'h0);
    rom_cs2 = 1'b0;
    rst_n   = 1'b1;
    tick();
    sdram_ack2 = 1'b1;
    tick();
    sdram_ack2 = 1'b0;
    chk("t7_late_ack_req", 32'(sdram_req2), 32'h0);
    tick();
    chk("t7_idle_req", 32'(sdram_req2), 32'h0);
    rom_cs2 = 1'b1;
    tick();
    chk("t7_new_req",  32'(sdram_req2),  32'h1);
    chk("t7_new_addr", 32'(sdram_addr2), 32'h000001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
